// File: rtl/codeword_serializer_pkg.sv
// Shared types and sizes for the codeword serializer: FSM states and frame geometry.
package codeword_ser_pkg;

   localparam int CODE_W     = 5;
   localparam int FRAME_BITS = 8;
   localparam int COUNT_W    = 4;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } ser_state_t;

   function automatic logic even_par(input logic [CODE_W-1:0] i_c);
      return ^i_c;
   endfunction

endpackage

// File: rtl/codeword_serializer_if.sv
// Codeword in / framed serial out bundle between the encoder tile and the serializer.
interface codeword_serializer_if;

   logic [codeword_ser_pkg::CODE_W-1:0]  i_code;
   logic                                 i_load;
   logic                                 o_sdo;
   logic                                 o_frame;
   logic                                 o_busy;
   logic                                 o_ovf;
   logic [codeword_ser_pkg::COUNT_W-1:0] o_count;

   modport master (
      output i_code, i_load,
      input  o_sdo, o_frame, o_busy, o_ovf, o_count
   );

   modport slave (
      input  i_code, i_load,
      output o_sdo, o_frame, o_busy, o_ovf, o_count
   );

endinterface

// File: rtl/codeword_serializer_bit_timer.sv
// Bit-time divider: o_bit_tick marks the last clock of each DIV-cycle bit-time.
module ser_bit_timer #(
   parameter int DIV = 1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_run,
   input  logic i_restart,
   output logic o_bit_tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] r_cnt;

   assign o_bit_tick = (r_cnt == CW'(DIV - 1));

   // Held at zero while idle so the first bit-time of a frame is always full length.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_restart || !i_run || o_bit_tick)
         r_cnt <= '0;
      else
         r_cnt <= r_cnt + CW'(1);
   end

endmodule

// File: rtl/codeword_serializer.sv
// Captures a codeword on a load rising edge and shifts it out as start/5 data LSB-first/even parity/stop.
module codeword_serializer
   import codeword_ser_pkg::*;
#(
   parameter int DIV = 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   codeword_serializer_if.slave  bus
);

   ser_state_t          r_state, w_state_nxt;
   logic [CODE_W-1:0]   r_shreg, w_shreg_nxt;
   logic                r_par, w_par_nxt;
   logic [2:0]          r_bit_idx, w_bit_idx_nxt;
   logic                r_load_q;
   logic                r_sdo, r_frame, r_busy, r_ovf;
   logic [COUNT_W-1:0]  r_count;

   logic w_edge, w_tick, w_capture, w_done, w_drop, w_sdo_nxt;

   assign w_edge = bus.i_load & ~r_load_q;

   ser_bit_timer #(.DIV(DIV)) u_timer (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_run      (r_state != IDLE),
      .i_restart  (w_capture),
      .o_bit_tick (w_tick)
   );

   always_comb begin
      w_state_nxt   = r_state;
      w_shreg_nxt   = r_shreg;
      w_par_nxt     = r_par;
      w_bit_idx_nxt = r_bit_idx;
      w_capture     = 1'b0;
      w_done        = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_edge) begin
               w_capture   = 1'b1;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_tick) begin
               w_state_nxt   = DATA;
               w_bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == 3'(CODE_W - 1)) begin
                  w_state_nxt = PARITY;
               end else begin
                  w_shreg_nxt   = r_shreg >> 1;
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
         PARITY: begin
            if (w_tick) w_state_nxt = STOP;
         end
         STOP: begin
            // Final stop cycle is the one window where a new load chains without an idle gap.
            if (w_tick) begin
               w_done = 1'b1;
               if (w_edge) begin
                  w_capture   = 1'b1;
                  w_state_nxt = START;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      if (w_capture) begin
         w_shreg_nxt = bus.i_code;
         w_par_nxt   = even_par(bus.i_code);
      end

      w_drop = w_edge && (r_state != IDLE) && !w_capture;

      case (w_state_nxt)
         START:   w_sdo_nxt = 1'b0;
         DATA:    w_sdo_nxt = w_shreg_nxt[0];
         PARITY:  w_sdo_nxt = w_par_nxt;
         default: w_sdo_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_shreg   <= '0;
         r_par     <= 1'b0;
         r_bit_idx <= '0;
         r_load_q  <= 1'b1;
         r_sdo     <= 1'b1;
         r_frame   <= 1'b0;
         r_busy    <= 1'b0;
         r_ovf     <= 1'b0;
         r_count   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_shreg   <= w_shreg_nxt;
         r_par     <= w_par_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_load_q  <= bus.i_load;
         r_sdo     <= w_sdo_nxt;
         r_frame   <= (w_state_nxt != IDLE);
         r_busy    <= (w_state_nxt != IDLE);
         if (w_drop) r_ovf <= 1'b1;
         if (w_done) r_count <= r_count + COUNT_W'(1);
      end
   end

   assign bus.o_sdo   = r_sdo;
   assign bus.o_frame = r_frame;
   assign bus.o_busy  = r_busy;
   assign bus.o_ovf   = r_ovf;
   assign bus.o_count = r_count;

endmodule

// File: tb/tb_codeword_serializer.sv
// Bench for codeword_serializer: DIV=1 and DIV=3 instances checked against a bit-time reference model.
module tb_codeword_serializer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   codeword_serializer_if bus1();
   codeword_serializer_if bus3();

   codeword_serializer #(.DIV(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus1));
   codeword_serializer #(.DIV(3)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

   int   n_checks = 0;
   int   n_fail   = 0;
   int   exp_cnt[2];
   logic exp_ovf[2];

   function automatic int div_of(input int sel);
      return (sel != 0) ? 3 : 1;
   endfunction

   // {count, ovf, busy, frame, sdo}
   function automatic logic [7:0] outs(input int sel);
      if (sel != 0) return {bus3.o_count, bus3.o_ovf, bus3.o_busy, bus3.o_frame, bus3.o_sdo};
      return {bus1.o_count, bus1.o_ovf, bus1.o_busy, bus1.o_frame, bus1.o_sdo};
   endfunction

   // Line value during bit-time bt of a frame carrying c.
   function automatic logic ref_bit(input logic [4:0] c, input int bt);
      int ones;
      if (bt == 0) return 1'b0;
      if (bt <= 5) return c[bt-1];
      if (bt == 6) begin
         ones = 0;
         for (int k = 0; k < 5; k++) ones += int'(c[k]);
         return (ones % 2) == 1;
      end
      return 1'b1;
   endfunction

   function automatic logic [7:0] idle_word(input int sel);
      return {4'(exp_cnt[sel]), exp_ovf[sel], 3'b001};
   endfunction

   task automatic drive(input int sel, input logic ld, input logic [4:0] c);
      if (sel != 0) begin
         bus3.i_load = ld;
         bus3.i_code = c;
      end else begin
         bus1.i_load = ld;
         bus1.i_code = c;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 1'b0, 5'd0);
      drive(1, 1'b0, 5'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_cnt = '{0, 0};
      exp_ovf = '{1'b0, 1'b0};
   endtask

   // Raise load with code; returns at the negedge of the first (start) cycle.
   task automatic launch(input int sel, input logic [4:0] c);
      @(negedge clk);
      drive(sel, 1'b1, c);
      @(negedge clk);
   endtask

   // Walks one frame from its start cycle; optional load pulse at cycle inj_at.
   task automatic check_frame(input int sel, input logic [4:0] c, input int inj_at,
                              input logic [4:0] inj_code, input string tag);
      logic q[$];
      logic [7:0] o;
      int d;
      d = div_of(sel);
      for (int bt = 0; bt < 8; bt++)
         for (int k = 0; k < d; k++) q.push_back(ref_bit(c, bt));
      for (int i = 0; i < 8 * d; i++) begin
         if (i > 0) @(negedge clk);
         o = outs(sel);
         if (i == 0) drive(sel, 1'b0, 5'($urandom));
         if (i == inj_at) drive(sel, 1'b1, inj_code);
         else if (i == inj_at + 1) drive(sel, 1'b0, 5'($urandom));
         n_checks++;
         if (o[0] !== q[i]) begin
            n_fail++;
            $display("FAIL %s_sdo sel=%0d cyc=%0d got=%b exp=%b", tag, sel, i, o[0], q[i]);
         end
         n_checks++;
         if ({o[7:4], o[2:1]} !== {4'(exp_cnt[sel]), 2'b11}) begin
            n_fail++;
            $display("FAIL %s_status sel=%0d cyc=%0d got cnt=%0d busy=%b frame=%b exp cnt=%0d busy=1 frame=1",
                     tag, sel, i, o[7:4], o[2], o[1], exp_cnt[sel]);
         end
      end
   endtask

   task automatic test_reset();
      logic [7:0] o;
      @(negedge clk);
      rst_n = 1'b0;
      drive(0, 1'b1, 5'd0);
      drive(1, 1'b1, 5'd0);
      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         o = outs(s);
         n_checks++;
         if (o !== 8'b0000_0001) begin
            n_fail++;
            $display("FAIL reset_vals sel=%0d got=%b exp=%b", s, o, 8'b0000_0001);
         end
      end
      do_reset();
   endtask

   task automatic test_frames(input int sel, input logic [4:0] first);
      logic [4:0] c;
      do_reset();
      for (int f = 0; f < 4; f++) begin
         c = (f == 0) ? first : 5'($urandom_range(0, 31));
         launch(sel, c);
         check_frame(sel, c, -1, 5'd0, "frame");
         @(negedge clk);
         exp_cnt[sel] = (exp_cnt[sel] + 1) % 16;
         n_checks++;
         if (outs(sel) !== idle_word(sel)) begin
            n_fail++;
            $display("FAIL frame_end sel=%0d code=%b got=%b exp=%b", sel, c, outs(sel), idle_word(sel));
         end
      end
   endtask

   task automatic test_overflow(input int sel);
      logic [4:0] c;
      do_reset();
      c = 5'($urandom_range(0, 31));
      launch(sel, c);
      check_frame(sel, c, 3 * div_of(sel), ~c, "ovf");
      exp_ovf[sel] = 1'b1;
      exp_cnt[sel] = 1;
      for (int i = 0; i < 3 * div_of(sel) + 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (outs(sel) !== idle_word(sel)) begin
            n_fail++;
            $display("FAIL ovf_after sel=%0d cyc=%0d got=%b exp=%b", sel, i, outs(sel), idle_word(sel));
         end
      end
   endtask

   task automatic test_back_to_back(input int sel);
      logic [4:0] c;
      do_reset();
      c = 5'($urandom_range(0, 30));
      launch(sel, c);
      check_frame(sel, c, 8 * div_of(sel) - 1, 5'b11111, "b2b_first");
      @(negedge clk);
      exp_cnt[sel] = 1;
      check_frame(sel, 5'b11111, -1, 5'd0, "b2b_second");
      @(negedge clk);
      exp_cnt[sel] = 2;
      n_checks++;
      if (outs(sel) !== idle_word(sel)) begin
         n_fail++;
         $display("FAIL b2b_end sel=%0d got=%b exp=%b", sel, outs(sel), idle_word(sel));
      end
   endtask

   task automatic test_reset_midframe();
      logic [4:0] c;
      do_reset();
      c = 5'b10101;
      launch(1, c);
      drive(1, 1'b0, 5'd0);
      repeat (3 * 3) @(negedge clk);
      n_checks++;
      if (outs(1) !== {4'd0, 4'b0111}) begin
         n_fail++;
         $display("FAIL mid_data2 got=%b exp=%b", outs(1), {4'd0, 4'b0111});
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_checks++;
      if (outs(1) !== 8'b0000_0001) begin
         n_fail++;
         $display("FAIL mid_abort got=%b exp=%b", outs(1), 8'b0000_0001);
      end
      drive(0, 1'b1, 5'd3);
      drive(1, 1'b1, 5'd3);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         for (int s = 0; s < 2; s++) begin
            n_checks++;
            if (outs(s) !== 8'b0000_0001) begin
               n_fail++;
               $display("FAIL load_held sel=%0d cyc=%0d got=%b exp=%b", s, i, outs(s), 8'b0000_0001);
            end
         end
      end
      drive(0, 1'b0, 5'd0);
      drive(1, 1'b0, 5'd0);
   endtask

   task automatic test_count_wrap();
      logic [4:0] c;
      do_reset();
      for (int f = 1; f <= 17; f++) begin
         c = 5'($urandom_range(0, 31));
         launch(0, c);
         check_frame(0, c, -1, 5'd0, "wrap");
         @(negedge clk);
         exp_cnt[0] = f % 16;
         n_checks++;
         if (outs(0) !== {4'(f % 16), 4'b0001}) begin
            n_fail++;
            $display("FAIL wrap_count frame=%0d got=%b exp=%b", f, outs(0), {4'(f % 16), 4'b0001});
         end
      end
   endtask

   initial begin
      drive(0, 1'b0, 5'd0);
      drive(1, 1'b0, 5'd0);
      test_reset();
      test_frames(0, 5'b10110);
      test_frames(1, 5'b00001);
      test_overflow(0);
      test_overflow(1);
      test_back_to_back(0);
      test_back_to_back(1);
      test_reset_midframe();
      test_count_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
